seq_decoder: RTL and testbench



---
 rtl/seq_decoder_pkg.sv | 21 ++
 rtl/seq_decoder_onehot_dec.sv | 16 +
 rtl/seq_decoder.sv | 167 ++++++++++++++++
 tb/tb_seq_decoder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared encodings for the registered one-hot decoder.
package seq_decoder_pkg;

  // Operating mode as presented on the mode port.
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Pulse-mode controller states.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pstate_t;

  // Width of a counter that must hold 0..v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational N-to-2^N one-hot decode with enable.
module onehot_dec #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] y
);

  // Single hot bit at position sel, all zero when disabled.
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/seq_decoder.sv
// Registered one-hot decoder with direct, scan and timed-pulse behaviours.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned LAST  = 2**N - 1,
  parameter int unsigned DWELL = 1,
  parameter int unsigned PULSE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    in,
  input  logic            enable,
  input  logic            start,
  output logic [2**N-1:0] D,
  output logic [N-1:0]    idx,
  output logic            valid,
  output logic            busy,
  output logic            wrap
);

  localparam int unsigned     DW         = cnt_width(DWELL);
  localparam int unsigned     PW         = cnt_width(PULSE);
  localparam logic [N-1:0]    LAST_IDX   = N'(LAST);
  localparam logic [DW-1:0]   DWELL_END  = DW'(DWELL - 1);
  localparam logic [PW-1:0]   PULSE_LOAD = PW'(PULSE - 1);

  logic [1:0]      mode_q;
  pstate_t         state;
  logic [DW-1:0]   dcnt;
  logic [PW-1:0]   pcnt;
  logic            primed;

  logic            mode_chg;
  logic            scan_adv;
  logic [N-1:0]    scan_next;
  logic [N-1:0]    dec_sel;
  logic [2**N-1:0] dec;

  // Next-channel selection; scan drives the channel it is about to show,
  // direct and pulse drive the external select.
  always_comb begin
    mode_chg  = (mode != mode_q);
    scan_adv  = primed && (dcnt == DWELL_END);
    scan_next = (idx == LAST_IDX) ? '0 : idx + N'(1);
    dec_sel   = in;
    if (mode == MODE_SCAN) begin
      if (!primed)       dec_sel = '0;
      else if (scan_adv) dec_sel = scan_next;
      else               dec_sel = idx;
    end
  end

  onehot_dec #(.N(N)) u_dec (
    .sel (dec_sel),
    .en  (enable),
    .y   (dec)
  );

  // Output registers, scan position, dwell counter and pulse controller.
  // primed=0 marks a fresh scan entry: idx keeps its old value (D is zero)
  // until the first enabled cycle loads channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      state  <= IDLE;
      dcnt   <= '0;
      pcnt   <= '0;
      primed <= 1'b0;
      D      <= '0;
      idx    <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        state  <= IDLE;
        dcnt   <= '0;
        pcnt   <= '0;
        primed <= 1'b0;
        D      <= '0;
        valid  <= 1'b0;
        busy   <= 1'b0;
        wrap   <= 1'b0;
      end else begin
        case (mode)
          MODE_DIRECT: begin
            D     <= dec;
            valid <= enable;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            if (enable) idx <= in;
          end
          MODE_SCAN: begin
            busy <= 1'b0;
            if (enable) begin
              D     <= dec;
              valid <= 1'b1;
              if (!primed) begin
                primed <= 1'b1;
                idx    <= '0;
                dcnt   <= '0;
                wrap   <= 1'b0;
              end else if (scan_adv) begin
                idx  <= scan_next;
                dcnt <= '0;
                wrap <= (idx == LAST_IDX);
              end else begin
                dcnt <= dcnt + DW'(1);
                wrap <= 1'b0;
              end
            end else begin
              D     <= '0;
              valid <= 1'b0;
              wrap  <= 1'b0;
            end
          end
          MODE_PULSE: begin
            wrap <= 1'b0;
            case (state)
              IDLE: begin
                if (enable && start) begin
                  state <= ACTIVE;
                  idx   <= in;
                  D     <= dec;
                  valid <= 1'b1;
                  busy  <= 1'b1;
                  pcnt  <= PULSE_LOAD;
                end else begin
                  D     <= '0;
                  valid <= 1'b0;
                  busy  <= 1'b0;
                end
              end
              ACTIVE: begin
                if (!enable || (pcnt == '0)) begin
                  state <= IDLE;
                  pcnt  <= '0;
                  D     <= '0;
                  valid <= 1'b0;
                  busy  <= 1'b0;
                end else begin
                  pcnt <= pcnt - PW'(1);
                end
              end
              default: state <= IDLE;
            endcase
          end
          default: begin
            state  <= IDLE;
            dcnt   <= '0;
            pcnt   <= '0;
            primed <= 1'b0;
            D      <= '0;
            idx    <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench: N=3/LAST=5/DWELL=2/PULSE=4 instance against a
// behavioural model, plus a default N=5 instance for the direct decode.
module tb_seq_decoder;

  localparam int unsigned N     = 3;
  localparam int unsigned LAST  = 5;
  localparam int unsigned DWELL = 2;
  localparam int unsigned PULSE = 4;
  localparam int unsigned P     = (LAST + 1) * DWELL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [2:0] in_s;
  logic       enable, start;
  logic [7:0] D;
  logic [2:0] idx;
  logic       valid, busy, wrap;

  logic [1:0]  mode5;
  logic [4:0]  in5;
  logic        en5, start5;
  logic [31:0] D5;
  logic [4:0]  idx5;
  logic        valid5, busy5, wrap5;

  int checks   = 0;
  int failures = 0;

  // Model state: enabled scan cycles since entry, pulse cycles left high.
  int unsigned m_prev, steps, left;
  logic [7:0]  eD;
  logic [2:0]  eidx;
  logic        ebusy, ewrap;

  always #5 clk = ~clk;

  seq_decoder #(.N(N), .LAST(LAST), .DWELL(DWELL), .PULSE(PULSE)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in(in_s), .enable(enable),
    .start(start), .D(D), .idx(idx), .valid(valid), .busy(busy), .wrap(wrap)
  );

  seq_decoder dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .in(in5), .enable(en5),
    .start(start5), .D(D5), .idx(idx5), .valid(valid5), .busy(busy5), .wrap(wrap5)
  );

  task automatic model_reset();
    m_prev = 0; steps = 0; left = 0;
    eD = '0; eidx = '0; ebusy = 1'b0; ewrap = 1'b0;
  endtask

  task automatic model_step();
    int unsigned ch;
    if (int'(mode) != m_prev) begin
      eD = '0; ebusy = 1'b0; ewrap = 1'b0; steps = 0; left = 0;
      m_prev = mode;
    end else begin
      case (mode)
        2'b00: begin
          ebusy = 1'b0; ewrap = 1'b0;
          if (enable) begin eD = 8'd1 << in_s; eidx = in_s; end
          else eD = '0;
        end
        2'b01: begin
          ebusy = 1'b0;
          if (enable) begin
            ch    = (steps / DWELL) % (LAST + 1);
            eD    = 8'd1 << ch;
            eidx  = 3'(ch);
            ewrap = (steps >= P) && (steps % P == 0);
            steps++;
          end else begin
            eD = '0; ewrap = 1'b0;
          end
        end
        2'b10: begin
          ewrap = 1'b0;
          if (left > 0) begin
            if (!enable || left == 1) begin left = 0; eD = '0; ebusy = 1'b0; end
            else left--;
          end else if (enable && start) begin
            left = PULSE; eidx = in_s; eD = 8'd1 << in_s; ebusy = 1'b1;
          end else begin
            eD = '0; ebusy = 1'b0;
          end
        end
        default: begin
          eD = '0; eidx = '0; ebusy = 1'b0; ewrap = 1'b0; steps = 0; left = 0;
        end
      endcase
    end
  endtask

  // One clock: update the model with the inputs sampled at the edge, then
  // settle past the edge so outputs can be read.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; in_s = '0; enable = 1'b0; start = 1'b0;
    mode5 = 2'b00; in5 = '0; en5 = 1'b0; start5 = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({D, idx, valid, busy, wrap, D5, idx5, valid5, busy5, wrap5} !== '0) begin
      failures++;
      $display("FAIL reset: D=%h idx=%0d v=%b b=%b w=%b D5=%h idx5=%0d required all zero",
               D, idx, valid, busy, wrap, D5, idx5);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_direct5();
    in5 = 5'd19; en5 = 1'b1;
    tick();
    checks++;
    if (D5 !== 32'h0008_0000 || idx5 !== 5'd19 || valid5 !== 1'b1) begin
      failures++;
      $display("FAIL direct5_on: D=%h idx=%0d v=%b required D=00080000 idx=19 v=1", D5, idx5, valid5);
    end
    en5 = 1'b0; in5 = 5'd3;
    tick();
    checks++;
    if (D5 !== 32'h0 || idx5 !== 5'd19 || valid5 !== 1'b0) begin
      failures++;
      $display("FAIL direct5_off: D=%h idx=%0d v=%b required D=0 idx=19 v=0", D5, idx5, valid5);
    end
  endtask

  task automatic test_direct_random();
    mode = 2'b00;
    for (int i = 0; i < 24; i++) begin
      in_s = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL direct[%0d]: D=%h idx=%0d v=%b b=%b w=%b required D=%h idx=%0d v=%b b=%b w=%b",
                 i, D, idx, valid, busy, wrap, eD, eidx, (eD != 0), ebusy, ewrap);
      end
    end
  endtask

  task automatic test_scan();
    int wraps = 0;
    mode = 2'b01; enable = 1'b1;
    tick();
    checks++;
    if (D !== 8'h00 || valid !== 1'b0) begin
      failures++;
      $display("FAIL scan_entry: D=%h v=%b required D=00 v=0", D, valid);
    end
    for (int k = 0; k < 2 * P + 1; k++) begin
      tick();
      if (wrap) wraps++;
      checks++;
      if (idx !== 3'((k / 2) % 6) || D !== (8'd1 << ((k / 2) % 6)) || wrap !== (k == 12 || k == 24)) begin
        failures++;
        $display("FAIL scan_seq[%0d]: idx=%0d D=%h w=%b required idx=%0d w=%b",
                 k, idx, D, wrap, (k / 2) % 6, (k == 12 || k == 24));
      end
      checks++;
      if ({D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL scan_model[%0d]: D=%h idx=%0d v=%b w=%b required D=%h idx=%0d w=%b",
                 k, D, idx, valid, wrap, eD, eidx, ewrap);
      end
    end
    checks++;
    if (wraps != 2) begin
      failures++;
      $display("FAIL scan_wrap_count: got %0d required 2", wraps);
    end
  endtask

  task automatic test_scan_pause();
    mode = 2'b00; tick();
    mode = 2'b01; enable = 1'b1; tick();
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (idx !== 3'd3 || D !== 8'h08) begin
      failures++;
      $display("FAIL pause_pre: idx=%0d D=%h required idx=3 D=08", idx, D);
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (D !== 8'h00 || valid !== 1'b0 || idx !== 3'd3) begin
        failures++;
        $display("FAIL pause[%0d]: D=%h v=%b idx=%0d required D=00 v=0 idx=3", k, D, valid, idx);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (idx !== (k == 0 ? 3'd3 : 3'd4) || {D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL resume[%0d]: D=%h idx=%0d w=%b required D=%h idx=%0d w=%b",
                 k, D, idx, wrap, eD, eidx, ewrap);
      end
    end
  endtask

  task automatic test_pulse();
    int high = 0;
    mode = 2'b10; enable = 1'b1; start = 1'b0; tick();
    start = 1'b1; in_s = 3'd7;
    for (int c = 0; c < 7; c++) begin
      tick();
      // c=0..3 are the four active cycles: start again on the 2nd and 4th
      start = (c == 0 || c == 2);
      in_s  = 3'($urandom_range(0, 6));
      if (busy) high++;
      checks++;
      if (D !== (c < 4 ? 8'h80 : 8'h00) || busy !== (c < 4) || {D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL pulse[%0d]: D=%h idx=%0d v=%b b=%b required D=%h idx=%0d b=%b",
                 c, D, idx, valid, busy, eD, eidx, ebusy);
      end
      if (c == 3) start = 1'b1;
      else if (c > 3) start = 1'b0;
    end
    checks++;
    if (high != PULSE) begin
      failures++;
      $display("FAIL pulse_len: busy cycles %0d required %0d", high, PULSE);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; in_s = 3'd3; enable = 1'b1;
    tick(); start = 1'b0;
    tick(); enable = 1'b0;
    tick();
    checks++;
    if (D !== 8'h00 || busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_enable: D=%h b=%b v=%b required D=00 b=0 v=0", D, busy, valid);
    end
    enable = 1'b1; start = 1'b1; in_s = 3'd2;
    tick(); start = 1'b0;
    tick(); mode = 2'b01;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (D !== (c == 0 ? 8'h00 : 8'h01) || busy !== 1'b0 || {D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL abort_mode[%0d]: D=%h idx=%0d b=%b required D=%h idx=%0d b=%b",
                 c, D, idx, busy, eD, eidx, ebusy);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({D, idx, valid, busy, wrap, D5, idx5, valid5} !== '0) begin
      failures++;
      $display("FAIL async_reset: D=%h idx=%0d v=%b b=%b w=%b D5=%h required all zero",
               D, idx, valid, busy, wrap, D5);
    end
    tick();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (D !== (c == 0 ? 8'h00 : 8'h01) || {D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL post_reset[%0d]: D=%h idx=%0d w=%b required D=%h idx=%0d w=%b",
                 c, D, idx, wrap, eD, eidx, ewrap);
      end
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      in_s   = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if ({D, idx, valid, busy, wrap} !== {eD, eidx, (eD != 0), ebusy, ewrap}) begin
        failures++;
        $display("FAIL random[%0d] mode=%0d: D=%h idx=%0d v=%b b=%b w=%b required D=%h idx=%0d v=%b b=%b w=%b",
                 i, mode, D, idx, valid, busy, wrap, eD, eidx, (eD != 0), ebusy, ewrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct5();
    test_direct_random();
    test_scan();
    test_scan_pause();
    test_pulse();
    test_abort();
    test_async_reset();
    test_random_mix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
